// File: rtl/cpu_pkg.sv
// Types and widths shared by the CPU-domain fetch front-end.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 64;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [ADDR_W-1:0] pc;
    logic              fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with flush; head is zero when empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: one outstanding read, prefetch FIFO toward decode.
// Latency: a response in cycle N is at the decode head in N+1, and the next request issues in N+1.
// Backpressure: a request is held while the FIFO has no free slot; decode stalls via inst_ready.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [CW-1:0]     count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              outstanding;
  logic [1:0]        unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // Pushes only happen in WAIT, so free space cannot vanish under a pending request.
  assign mem_req_valid = !reset && (state == FETCH) && (count < CW'(FIFO_DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign push       = (state == WAIT) && mem_rsp_valid && !redirect_valid;
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign push_entry = '{data: mem_rsp_data, pc: req_pc, fault: mem_rsp_err};

  // A read is still in flight after this cycle; its response must be drained.
  assign outstanding = (((state == WAIT) || (state == DRAIN)) && !mem_rsp_valid) || req_fire;

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = outstanding ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH:   if (req_fire) state_nxt = WAIT;
        WAIT:    if (mem_rsp_valid) state_nxt = mem_rsp_err ? HALT : FETCH;
        DRAIN:   if (mem_rsp_valid) state_nxt = FETCH;
        HALT:    state_nxt = HALT;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (req_fire) begin
        req_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_entry(push_entry),
    .head      (head),
    .count     (count)
  );

  assign inst_valid = (count != '0);
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;
  assign inst_fault = head.fault;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front-end for the CPU domain, directly upstream of decode and the ALU/regbank execute stage. Holds the fetch PC and issues one 32-bit instruction read at a time over a valid/ready memory port. Buffers returned words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake. Supports flush-and-redirect from branches and halts on memory faults.

## Interface
- RESET_PC, 64'h0: fetch address loaded on reset.
- FIFO_DEPTH, 4: prefetch entries; power of two, minimum 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req_valid  output  1  read request pending.
- mem_req_ready  input  1  memory accepts the request this cycle.
- mem_req_addr  output  64  word-aligned read address.
- mem_rsp_valid  input  1  read data returned this cycle; at most one per accepted request.
- mem_rsp_data  input  32  instruction word.
- mem_rsp_err  input  1  access fault; qualified by mem_rsp_valid.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  64  new fetch address; bits [1:0] are ignored and forced to 0.
- inst_valid  output  1  FIFO head is valid.
- inst_ready  input  1  decode consumes the head.
- inst_data  output  32  head instruction word.
- inst_pc  output  64  head instruction address.
- inst_fault  output  1  head came from an errored response.

## Operation
- **FSM states:**
  - FETCH: may issue a request.
  - WAIT: one request outstanding.
  - DRAIN: outstanding response must be discarded.
  - HALT: fault seen; no issue.
- **FETCH:**
  - mem_req_valid = (count < FIFO_DEPTH); combinational from state and count.
  - mem_req_addr = fetch_pc.
  - On valid && ready: record req_pc = fetch_pc, fetch_pc += 4 (mod 2^64, wraps silently), go to WAIT.
- **WAIT:**
  - On mem_rsp_valid: push {mem_rsp_data, req_pc, mem_rsp_err}.
  - Next state is HALT if err, else FETCH.
- **DRAIN:** on mem_rsp_valid, discard the response and go to FETCH.
- **HALT:** leave only on redirect.
- **Redirect** (highest priority, any state):
  - Flush the FIFO (count = 0) and set fetch_pc = {redirect_pc[63:2], 2'b00}.
  - Next state is DRAIN if a request is outstanding after this cycle, else FETCH.
  - Outstanding after this cycle means: in WAIT without mem_rsp_valid this cycle, or in DRAIN without mem_rsp_valid, or a request is accepted this same cycle.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is ignored.
- **Decode side:**
  - inst_valid = (count != 0).
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged.
- **Request stability:** once mem_req_valid is asserted, it and mem_req_addr stay stable until accepted.
  - Credit cannot drop while in FETCH, because pushes occur only in WAIT.
  - Redirect is the only exception: the unaccepted request is withdrawn and the new address is presented next cycle.

## Timing
- **Reset values:**
  - state = FETCH, fetch_pc = RESET_PC, count = 0.
  - mem_req_valid = 0 during reset.
  - inst_valid = 0, inst_data = 0, inst_pc = 0, inst_fault = 0.
- **Startup:** first request (addr RESET_PC) is asserted in the first cycle after reset deasserts.
- **Reset mid-operation:** any outstanding response arriving after reset is ignored (state FETCH, no WAIT).
- **Data path latency:**
  - mem_rsp_valid in cycle N gives inst_valid in N+1 (registered FIFO).
  - The next request issues in N+1.
- **Throughput:** with single-cycle memory, one instruction per 2 cycles.
- **Redirect:** redirect in cycle N gives mem_req_valid with the new address in N+1, unless DRAIN.
- **Full FIFO:** mem_req_valid stays low until a pop frees a slot; the request then issues the cycle after the pop.

## Structure
- **cpu_pkg shared package:**
  - fetch_state_t enum (FETCH, WAIT, DRAIN, HALT).
  - Constants INST_W = 32 and ADDR_W = 64.
  - fetch_entry_t struct {data, pc, fault}.
- **Sub-module fetch_fifo:**
  - Parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count and head outputs.
  - flush has priority over push and pop.

## Test plan
- **Reset and stream:** release reset; memory ready always, 1-cycle response with data = addr.
  - Requests go to 0x0, 0x4, 0x8.
  - inst_pc/inst_data pairs are 0/0, 4/4, 8/8 in order.
- **Backpressure:** hold inst_ready = 0.
  - Exactly 4 requests issue, then mem_req_valid stays 0.
  - Raise inst_ready for one cycle: exactly one new request follows.
- **Redirect with outstanding request:** request 0x10 accepted; redirect_pc = 0x1003 the next cycle; response for 0x10 arrives 3 cycles later.
  - The response is dropped.
  - The next request addr is 0x1000.
  - inst_valid stays 0 until the 0x1000 data returns.
- **Fault:** the response for 0x8 has err = 1.
  - The entry is delivered with inst_fault = 1, pc = 0x8.
  - No further requests until a redirect to 0x40, which resumes fetch at 0x40.
- **Wrap:** RESET_PC = 0xFFFF_FFFF_FFFF_FFFC gives a request at that address, then a request at 0x0.
- **Simultaneous events:** redirect, response and pop in the same cycle.
  - FIFO empties and the response is discarded.
  - The next cycle, mem_req_addr = the redirect target.
